io_mem_arbiter: RTL and testbench
=================================

# io_mem_arbiter

Shares one synchronous single-port IO scratch RAM between the CPU's IV-bus IO path and an auxiliary requester (DMA/UART engine). The CPU always wins a given cycle because its IO path cannot wait. The auxiliary side uses a req/ack handshake and is served in CPU-idle cycles. If the auxiliary side is starved, the block halts the CPU for one forced access. It sits between IO_mod/the right-bank decode and the scratch RAM; `cpu_stall` is inverted into the CPU's `n_halt` at top level.

## Interface
- AW, 8, address width of RAM and both ports
- DW, 8, data width
- STARVE_LIMIT, 4, consecutive blocked cycles (1..15) before forcing a stall
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_rd  in  1  CPU IO read strobe for this cycle
- cpu_wr  in  1  CPU IO write strobe for this cycle
- cpu_addr  in  AW  CPU IO address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid the cycle after cpu_rd, held until the next CPU read returns
- cpu_stall  out  1  registered; high requests CPU halt
- aux_req  in  1  auxiliary request; must be held with fields stable until aux_ack
- aux_we  in  1  1 = write, 0 = read
- aux_addr  in  AW  auxiliary address
- aux_wdata  in  DW  auxiliary write data
- aux_ack  out  1  registered one-cycle completion pulse
- aux_rdata  out  DW  read data, valid while aux_ack is high
- ram_addr  out  AW  RAM address (combinational mux)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, one cycle after address
- conflict  out  1  sticky error: CPU strobe seen during a forced access

## Operation
- States: IDLE, ACK, STALL_WAIT, FORCE.
- CPU path, any state except FORCE: a CPU strobe drives `ram_addr=cpu_addr`, `ram_we=cpu_wr`, `ram_wdata=cpu_wdata`.
  - cpu_rd and cpu_wr together: treated as a write.
  - A read sets `rd_pend`. In the next cycle, `cpu_rdata=ram_rdata` and the hold register captures it. Otherwise `cpu_rdata` is the hold register.
- IDLE with aux_req=1:
  - No CPU strobe: issue the aux access this cycle (RAM muxed to aux fields), clear wait_cnt, go to ACK.
  - CPU strobe present: wait_cnt+1. If wait_cnt+1 = STARVE_LIMIT, set cpu_stall and go to STALL_WAIT.
- IDLE with aux_req=0: wait_cnt cleared.
- ACK: aux_ack=1, aux_rdata=ram_rdata (write: aux_rdata = RAM read-during-write value, don't-care). aux_req is ignored this cycle. A CPU access is still allowed. Next state is IDLE.
- STALL_WAIT: one cycle for the halt to take effect. The CPU still has priority this cycle. Next state is FORCE.
- FORCE: RAM is muxed to aux unconditionally. Any cpu_rd/cpu_wr is dropped and sets `conflict`. A dropped read does not update the hold register. cpu_stall is cleared at the end of the cycle. Next state is ACK.
- wait_cnt is 4 bits and saturates; it is only meaningful in IDLE.
- Reset, at any time including mid-operation: state=IDLE, wait_cnt=0, cpu_stall=0, aux_ack=0, aux_rdata=0, cpu_rdata hold=0, rd_pend=0, conflict=0. A pending aux request is re-arbitrated from scratch after reset.

## Timing
- Uncontended aux access: req seen in cycle N, RAM access in N, aux_ack in N+1. Minimum aux issue interval is 2 cycles.
- CPU read: strobe in N, cpu_rdata valid in N+1.
- Starvation: with the CPU busy every cycle, the blocked cycles are N..N+L-1 (L=STARVE_LIMIT).
  - cpu_stall is high in N+L (STALL_WAIT) and N+L+1 (FORCE).
  - The forced access is in N+L+1; aux_ack is in N+L+2.
- cpu_stall is never high for more than 2 consecutive cycles.
- ram_* outputs are combinational from inputs and state; no extra latency.

## Test plan
- Idle CPU, aux write addr 0x10 data 0xA5, then aux read 0x10. Required: ack at N+1 for each; read ack carries aux_rdata=0xA5; cpu_stall stays 0.
- CPU write 0x20=0x3C, then CPU read 0x20 while aux_req is held. Required: cpu_rdata=0x3C one cycle after the read; aux is served in the first CPU-free cycle.
- CPU strobing every cycle with aux read of 0x10 pending, STARVE_LIMIT=4. Required: cpu_stall high exactly 2 cycles starting 4 cycles after req; aux_ack 6 cycles after req with 0xA5.
- Keep cpu_rd high during the FORCE cycle. Required: conflict=1 and remains 1; the aux access still completes; cpu_rdata keeps its previous value.
- Assert reset in STALL_WAIT with aux_req held. Required: all outputs 0 immediately; after release, the request is re-served normally with ack 1 cycle later if the CPU is idle.
- CPU read and aux request in the same cycle, then the CPU idles. Required: CPU data returns in N+1 with aux access also in N+1; aux_ack in N+2; cpu_rdata not disturbed by the aux read.

Source files
------------

// File: rtl/io_mem_arbiter.sv
// io_mem_arbiter: shares one single-port IO scratch RAM between the CPU IO path and an aux requester
module io_mem_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [DW-1:0] aux_wdata,
   output logic          aux_ack,
   output logic [DW-1:0] aux_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          conflict
);
   typedef enum logic [1:0] {IDLE, ACK, STALL_WAIT, FORCE} state_t;
   state_t        state_q, state_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d, wait_inc;
   logic          cpu_stall_q, cpu_stall_d;
   logic          aux_ack_q, aux_ack_d;
   logic          rd_pend_q, rd_pend_d;
   logic          conflict_q, conflict_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          cpu_strobe, is_force, aux_issue;
   // arbitration, RAM mux and next-state logic; CPU wins every cycle except FORCE
   always_comb begin
      cpu_strobe  = cpu_rd | cpu_wr;
      is_force    = state_q == FORCE;
      aux_issue   = is_force || (state_q == IDLE && aux_req && !cpu_strobe);
      wait_inc    = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
      state_d     = state_q;
      wait_cnt_d  = '0;
      case (state_q)
         IDLE: begin
            if (aux_req && !cpu_strobe) state_d = ACK;
            else if (aux_req) begin
               wait_cnt_d = wait_inc;
               state_d    = (wait_inc == 4'(STARVE_LIMIT)) ? STALL_WAIT : IDLE;
            end
         end
         ACK:        state_d = IDLE;
         STALL_WAIT: state_d = FORCE;
         default:    state_d = ACK;
      endcase
      ram_addr    = aux_issue ? aux_addr  : cpu_addr;
      ram_we      = aux_issue ? aux_we    : cpu_wr;
      ram_wdata   = aux_issue ? aux_wdata : cpu_wdata;
      rd_pend_d   = cpu_rd && !cpu_wr && !is_force;
      hold_d      = rd_pend_q ? ram_rdata : hold_q;
      conflict_d  = conflict_q | (is_force & cpu_strobe);
      cpu_stall_d = state_d == STALL_WAIT || state_d == FORCE;
      aux_ack_d   = state_d == ACK;
      cpu_rdata   = rd_pend_q ? ram_rdata : hold_q;
      aux_rdata   = aux_ack_q ? ram_rdata : '0;
      cpu_stall   = cpu_stall_q;
      aux_ack     = aux_ack_q;
      conflict    = conflict_q;
   end
   // state registers; reset drops any in-flight arbitration so a held request starts over
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         cpu_stall_q <= 1'b0;
         aux_ack_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         conflict_q  <= 1'b0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         cpu_stall_q <= cpu_stall_d;
         aux_ack_q   <= aux_ack_d;
         rd_pend_q   <= rd_pend_d;
         conflict_q  <= conflict_d;
         hold_q      <= hold_d;
      end
   end
endmodule

// File: tb/tb_io_mem_arbiter.sv
// tb_io_mem_arbiter: vector table plus scoreboard queues against a behavioural RAM
module tb_io_mem_arbiter;
   logic       clk = 1'b0, reset = 1'b1;
   logic       cpu_rd = 0, cpu_wr = 0, aux_req = 0, aux_we = 0;
   logic [7:0] cpu_addr = 0, cpu_wdata = 0, aux_addr = 0, aux_wdata = 0;
   logic [7:0] cpu_rdata, aux_rdata, ram_addr, ram_wdata, ram_rdata;
   logic       cpu_stall, aux_ack, ram_we, conflict;
   logic [7:0] mem [256] = '{default: 8'h00};
   int         total = 0, bad = 0;

   typedef struct {
      logic rd, wr; logic [7:0] ca, cd;
      logic req, we; logic [7:0] aa, ad;
      logic new_aux, aux_chk; logic [7:0] aux_d;
      logic cpu_chk; logic [7:0] cpu_d;
      logic stall, ack, conf, rwe;
   } vec_t;
   typedef struct { logic chk; logic [7:0] val; } aux_exp_t;

   vec_t       vecs [18];
   aux_exp_t   aux_q [$];
   logic [7:0] cpu_q [$];

   always #5 clk = ~clk;

   io_mem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_ack(aux_ack), .aux_rdata(aux_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .conflict(conflict)
   );

   // synchronous RAM, read-before-write
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   function automatic vec_t mk(input logic rd, wr, input logic [7:0] ca, cd,
                               input logic req, we, input logic [7:0] aa, ad,
                               input logic na, ac, input logic [7:0] axd,
                               input logic cc, input logic [7:0] cxd,
                               input logic st, ak, cf, rw);
      vec_t v;
      v.rd = rd; v.wr = wr; v.ca = ca; v.cd = cd;
      v.req = req; v.we = we; v.aa = aa; v.ad = ad;
      v.new_aux = na; v.aux_chk = ac; v.aux_d = axd;
      v.cpu_chk = cc; v.cpu_d = cxd;
      v.stall = st; v.ack = ak; v.conf = cf; v.rwe = rw;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_hold;
      logic       prev_cc;
      aux_exp_t   e;
      //                rd wr ca     cd     rq we aa     ad     na ac axd    cc cxd    st ak cf rw
      vecs[0]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
      vecs[1]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
      vecs[2]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 1, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
      vecs[4]  = mk(0, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
      vecs[5]  = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 1, 1, 8'hA5, 1, 8'h3C, 0, 0, 0, 0);
      vecs[6]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
      vecs[7]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
      vecs[8]  = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 1, 1, 8'hA5, 1, 8'h3C, 0, 0, 0, 0);
      vecs[9]  = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 0, 0, 0, 0);
      vecs[10] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 0, 0, 0, 0);
      vecs[11] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 0, 0, 0, 0);
      vecs[12] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 1, 0, 0, 0);
      vecs[13] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
      vecs[14] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0);
      vecs[15] = mk(1, 1, 8'h50, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1);
      vecs[16] = mk(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'h11, 0, 0, 1, 0);
      vecs[17] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);

      #2;
      chk("reset stall", {7'd0, cpu_stall}, 8'h00);
      chk("reset ack", {7'd0, aux_ack}, 8'h00);
      chk("reset cpu_rdata", cpu_rdata, 8'h00);
      chk("reset conflict", {7'd0, conflict}, 8'h00);
      @(negedge clk) reset = 1'b0;

      exp_hold = 8'h00;
      prev_cc  = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
         aux_req = vecs[i].req; aux_we = vecs[i].we; aux_addr = vecs[i].aa; aux_wdata = vecs[i].ad;
         if (vecs[i].new_aux) aux_q.push_back('{vecs[i].aux_chk, vecs[i].aux_d});
         if (vecs[i].cpu_chk) cpu_q.push_back(vecs[i].cpu_d);
         @(negedge clk);
         chk($sformatf("r%0d stall", i), {7'd0, cpu_stall}, {7'd0, vecs[i].stall});
         chk($sformatf("r%0d ack", i), {7'd0, aux_ack}, {7'd0, vecs[i].ack});
         chk($sformatf("r%0d conflict", i), {7'd0, conflict}, {7'd0, vecs[i].conf});
         chk($sformatf("r%0d ram_we", i), {7'd0, ram_we}, {7'd0, vecs[i].rwe});
         if (prev_cc) begin
            if (cpu_q.size() == 0) begin
               bad++; total++;
               $display("FAIL r%0d cpu_q: got empty want entry", i);
            end else exp_hold = cpu_q.pop_front();
         end
         chk($sformatf("r%0d cpu_rdata", i), cpu_rdata, exp_hold);
         if (aux_ack) begin
            if (aux_q.size() == 0) begin
               bad++; total++;
               $display("FAIL r%0d aux_ack: got unexpected ack want none", i);
            end else begin
               e = aux_q.pop_front();
               if (e.chk) chk($sformatf("r%0d aux_rdata", i), aux_rdata, e.val);
            end
         end
         prev_cc = vecs[i].cpu_chk;
      end
      chk("aux_q drained", 8'(aux_q.size()), 8'h00);
      chk("cpu_q drained", 8'(cpu_q.size()), 8'h00);

      // starve the aux side with CPU writes, then reset while in STALL_WAIT
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         cpu_wr = 1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
         aux_req = 1; aux_we = 0; aux_addr = 8'h10;
         @(negedge clk);
         chk($sformatf("starve%0d stall", i), {7'd0, cpu_stall}, (i == 4) ? 8'h01 : 8'h00);
      end
      reset = 1'b1; cpu_wr = 0;
      #1;
      chk("rst stall", {7'd0, cpu_stall}, 8'h00);
      chk("rst ack", {7'd0, aux_ack}, 8'h00);
      chk("rst aux_rdata", aux_rdata, 8'h00);
      chk("rst cpu_rdata", cpu_rdata, 8'h00);
      chk("rst conflict", {7'd0, conflict}, 8'h00);
      chk("rst ram_we", {7'd0, ram_we}, 8'h00);
      @(posedge clk); #1;
      chk("rst held stall", {7'd0, cpu_stall}, 8'h00);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("rearb ack", {7'd0, aux_ack}, 8'h01);
      chk("rearb aux_rdata", aux_rdata, 8'hA5);
      chk("rearb stall", {7'd0, cpu_stall}, 8'h00);
      aux_req = 0;
      @(negedge clk);
      chk("rearb ack drop", {7'd0, aux_ack}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
